fft_frame_sequencer: RTL

- Sequences the 256-point FFT input scrambler.
- Drives the scrambler's 5-bit `cycle` select through 0..31 for one frame at a time.
- Registers each 8-lane mux output beat into a valid/ready pipeline stage feeding the butterfly datapath.
- Tells the input sample buffer when the frame has been fully read so it can refill.

---
 rtl/fft_frame_sequencer_if.sv | 37 +++
 rtl/fft_frame_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - beat stream from the frame sequencer to the butterfly datapath
//
// Purpose: groups the registered beat handshake into one bundle.
// Signals:
//   out_data   LANES*DW  registered beat, lane 0 in LSBs
//   out_valid  1         out_data holds an unconsumed beat
//   out_ready  1         sink accepts the beat when out_valid & out_ready
//   out_sof    1         beat is beat 0 of the frame
//   out_eof    1         beat is the last beat of the frame
// Modports: master (sequencer side), slave (datapath side).

interface fft_frame_sequencer_if #(
    parameter int LANES = 8,
    parameter int DW    = 56
);
    logic [LANES*DW-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_sof;
    logic                out_eof;

    modport master (
        output out_data,
        output out_valid,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame sequencer for the 256-point FFT input scrambler
//
// Purpose: steps the scrambler beat select through one frame, registers each
// mux beat into a valid/ready stage and signals buffer release / frame end.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         frame request (level, sampled in IDLE)
//   frame_rdy     input buffer holds a full frame
//   abort         synchronous frame cancel
//   cycle         beat select to the scrambler mux
//   mux_data      scrambler mux output for the current cycle
//   beat          registered beat stream (master side)
//   busy          sequencer not idle
//   buf_release   one-cycle pulse, last beat read from the buffer
//   frame_done    one-cycle pulse, last beat consumed downstream
//   frame_count   completed (non-aborted) frames, wrapping

module fft_frame_sequencer #(
    parameter int LANES = 8,
    parameter int DW    = 56,
    parameter int BEATS = 32,
    parameter int CW    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                frame_rdy,
    input  logic                abort,
    output logic [CW-1:0]       cycle,
    input  logic [LANES*DW-1:0] mux_data,
    fft_frame_sequencer_if.master beat,
    output logic                busy,
    output logic                buf_release,
    output logic                frame_done,
    output logic [15:0]         frame_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [1:0]          state_q,       state_d;
    logic [CW-1:0]       cycle_q,       cycle_d;
    logic [LANES*DW-1:0] data_q,        data_d;
    logic                valid_q,       valid_d;
    logic                sof_q,         sof_d;
    logic                eof_q,         eof_d;
    logic                release_q,     release_d;
    logic                done_q,        done_d;
    logic [15:0]         count_q,       count_d;

    logic load;
    logic consume;
    logic last_beat;

    // The output stage can take a new beat when empty or being drained this cycle.
    assign load      = !valid_q || beat.out_ready;
    assign consume   = valid_q && beat.out_ready;
    assign last_beat = (cycle_q == LAST_BEAT);

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        data_d    = data_q;
        valid_d   = valid_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        release_d = 1'b0;
        done_d    = 1'b0;
        count_d   = count_q;

        if (abort) begin
            // Cancel drops the pending beat; out_data keeps its stale value
            // since it is qualified by out_valid.
            state_d = S_IDLE;
            cycle_d = '0;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cycle_d = '0;
                    if (consume) begin
                        valid_d = 1'b0;
                    end
                    if (start && frame_rdy) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        data_d  = mux_data;
                        valid_d = 1'b1;
                        sof_d   = (cycle_q == '0);
                        eof_d   = last_beat;
                        if (!last_beat) begin
                            cycle_d = cycle_q + CW'(1);
                        end else begin
                            // Buffer has been fully read once the last beat is captured.
                            cycle_d   = '0;
                            release_d = 1'b1;
                            state_d   = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (consume) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cycle_d = '0;
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eof_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            release_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            release_q <= release_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign cycle          = cycle_q;
    assign beat.out_data  = data_q;
    assign beat.out_valid = valid_q;
    assign beat.out_sof   = sof_q;
    assign beat.out_eof   = eof_q;
    assign busy           = (state_q != S_IDLE);
    assign buf_release    = release_q;
    assign frame_done     = done_q;
    assign frame_count    = count_q;
endmodule
